// File: rtl/i2c_tx_pkg.sv
// Purpose: shared types and constants for the I2C FIFO transmit engine.
// Contents: FSM state enum, per-state quarter counts, bits per byte and
//           a helper returning the index of each state's final quarter.
package i2c_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int unsigned Q_START       = 2;
    localparam int unsigned Q_BIT         = 4;
    localparam int unsigned Q_ACK         = 4;
    localparam int unsigned Q_STOP        = 3;
    localparam int unsigned BITS_PER_BYTE = 8;

    // Quarter index on which a state ends; IDLE has no quarters.
    function automatic logic [1:0] last_quarter(input state_t s);
        logic [1:0] lq;
        lq = 2'd0;
        case (s)
            START:   lq = 2'(Q_START - 1);
            BIT:     lq = 2'(Q_BIT - 1);
            ACK:     lq = 2'(Q_ACK - 1);
            STOP:    lq = 2'(Q_STOP - 1);
            default: lq = 2'd0;
        endcase
        return lq;
    endfunction

endpackage

// File: rtl/i2c_fifo_transmitter_quarter_tick.sv
// Purpose: divides the clock into SCL quarter periods; tick_o pulses on the
//          last cycle of each quarter. Latency: tick after CLK_DIV running cycles.
// Ports: clk_i/rst_i, run_i (clears counter when low), hold_i (freezes counter), tick_o.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && !hold_i && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_fifo_transmitter.sv
// Purpose: I2C master transmit engine draining a TX FIFO: START, MSB-first bytes,
//          ACK sampling, STOP on drain/disable/NACK. All outputs registered.
// Ports: read_clk/read_reset, FIFO read side (read_data/read_empty/read_increment),
//        open-drain sda/scl in/out, status busy/byte_done/nack, nack_clear.
// Option: I2C_TX_STRETCH_EN enables slave clock stretching via scl_in.
module i2c_fifo_transmitter
    import i2c_tx_pkg::*;
#(
    parameter int unsigned data_size = 8,   // must equal BITS_PER_BYTE
    parameter int unsigned clk_div   = 4    // cycles per SCL quarter, >= 2
) (
    input  logic                 read_clk,
    input  logic                 read_reset,
    input  logic                 enable,
    input  logic [data_size-1:0] read_data,
    input  logic                 read_empty,
    output logic                 read_increment,
    input  logic                 sda_in,
    input  logic                 scl_in,
    output logic                 sda_out,
    output logic                 scl_out,
    output logic                 busy,
    output logic                 byte_done,
    output logic                 nack,
    input  logic                 nack_clear
);

    state_t                 state_q, state_d;
    logic [1:0]             q_q, q_d;
    logic [data_size-1:0]   shift_q, shift_d;
    logic [2:0]             bit_q, bit_d;
    logic                   ack_q, ack_d;      // sampled SDA in ACK slot, 1 = NACK
    logic                   nack_q, nack_d;
    logic                   nack_set;
    logic                   sda_q, sda_d;
    logic                   scl_q, scl_d;
    logic                   pop_q, pop_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   tick;
    logic                   hold;
    logic                   last;

`ifdef I2C_TX_STRETCH_EN
    // A released SCL still read low means the slave is stretching the clock.
    assign hold = scl_q && !scl_in;
`else
    assign hold = 1'b0;
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
`endif

    i2c_quarter_tick #(
        .CLK_DIV (clk_div)
    ) u_tick (
        .clk_i   (read_clk),
        .rst_i   (read_reset),
        .run_i   (state_q != IDLE),
        .hold_i  (hold),
        .tick_o  (tick)
    );

    assign last = tick && (q_q == last_quarter(state_q));

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        ack_d    = ack_q;
        pop_d    = 1'b0;
        done_d   = 1'b0;
        nack_set = 1'b0;

        if (tick) begin
            q_d = last ? 2'd0 : q_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                q_d = 2'd0;
                if (enable && !read_empty && !nack_q) begin
                    shift_d = read_data;
                    pop_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    bit_d   = 3'd0;
                    state_d = BIT;
                end
            end
            BIT: begin
                if (last) begin
                    shift_d = {shift_q[data_size-2:0], 1'b0};
                    bit_d   = bit_q + 3'd1;   // wraps 7->0 as the byte ends
                    if (bit_q == 3'(BITS_PER_BYTE - 1)) state_d = ACK;
                end
            end
            ACK: begin
                if (tick && q_q == 2'd2) ack_d = sda_in;
                if (last) begin
                    done_d = 1'b1;
                    if (!ack_q && enable && !read_empty) begin
                        shift_d = read_data;
                        pop_d   = 1'b1;
                        state_d = BIT;
                    end else begin
                        nack_set = ack_q;
                        state_d  = STOP;
                    end
                end
            end
            STOP: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A NACK arriving together with a clear request takes priority.
    assign nack_d = nack_set ? 1'b1 : (nack_clear ? 1'b0 : nack_q);

    // Line levels decoded from the next state so they change with the state register.
    always_comb begin
        sda_d  = 1'b1;
        scl_d  = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START: begin
                sda_d = 1'b0;
                scl_d = (q_d == 2'd0);
            end
            BIT: begin
                sda_d = shift_d[data_size-1];
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
            end
            ACK: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
            end
            STOP: begin
                sda_d = (q_d == 2'd2);
                scl_d = (q_d != 2'd0);
            end
            default: begin
                sda_d = 1'b1;
                scl_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            state_q <= IDLE;
            q_q     <= 2'd0;
            shift_q <= '0;
            bit_q   <= 3'd0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
            pop_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            sda_q   <= sda_d;
            scl_q   <= scl_d;
            pop_q   <= pop_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sda_out        = sda_q;
    assign scl_out        = scl_q;
    assign read_increment = pop_q;
    assign byte_done      = done_q;
    assign busy           = busy_q;
    assign nack           = nack_q;

endmodule
